// File: rtl/pico_pkg.sv
// Shared opcode, state and instruction-field definitions for the picoMips sequencer.
package pico_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_LI  = 3'b011,
    OP_HEN = 3'b100,
    OP_HEQ = 3'b101,
    OP_J   = 3'b110,
    OP_ILL = 3'b111
  } op_t;

  typedef enum logic [2:0] {
    FETCH,
    EXEC,
    MUL,
    WB,
    WAIT_HI,
    WAIT_LO
  } state_t;

  localparam int unsigned FUNC_LSB = 0;
  localparam int unsigned FUNC_W   = 3;
  localparam int unsigned RD_LSB   = 3;
  localparam int unsigned RD_W     = 4;
  localparam int unsigned RS_LSB   = 7;
  localparam int unsigned RS_W     = 4;
  localparam int unsigned IMM_LSB  = 7;
  localparam int unsigned IMM_W    = 8;

endpackage

// File: rtl/pico_mul_seq.sv
// Iterative unsigned DATA_W x DATA_W shift-add multiplier; one step per clock.
module pico_mul_seq #(
  parameter int unsigned DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  logic [2*DATA_W-1:0] mcand;
  logic [2*DATA_W-1:0] acc;
  logic [DATA_W-1:0]   mplier;
  logic [CNT_W-1:0]    count;
  logic                running;

  // done flags the last step, so the final add commits on the same edge the caller leaves MUL
  assign done    = running && (count == CNT_W'(DATA_W - 1));
  assign product = acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      count   <= '0;
      running <= 1'b0;
    end else if (start) begin
      mcand   <= {{DATA_W{1'b0}}, a};
      mplier  <= b;
      acc     <= '0;
      count   <= '0;
      running <= 1'b1;
    end else if (running) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 1'b1;
      if (done) running <= 1'b0;
    end
  end

endmodule

// File: rtl/pico_seq_ctrl.sv
// Multi-cycle picoMips sequencer: PC, IR, decode, register-file control, MUL and switch waits.
// Optional PICO_SW_SYNC_EN: passes sw_en through a 2-flop synchronizer before use.
module pico_seq_ctrl
  import pico_pkg::*;
#(
  parameter int unsigned PC_W   = 3,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned MUL_HI = 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [15:0]       instr,
  input  logic              sw_en,
  input  logic [DATA_W-1:0] rd_data,
  input  logic [DATA_W-1:0] rs_data,
  output logic [PC_W-1:0]   pc,
  output logic [3:0]        rf_addr_d,
  output logic [3:0]        rf_addr_s,
  output logic              rf_we,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              busy,
  output logic              illegal
);

  state_t              state, state_nx;
  logic [15:0]         ir;
  op_t                 op;
  logic [7:0]          imm;
  logic                sw;
  logic                mul_start, mul_done;
  logic [2*DATA_W-1:0] product;
  logic                pc_inc, pc_jump;
  logic                we_raw, illegal_raw;
  logic                unused_ir;

`ifdef PICO_SW_SYNC_EN
  logic [1:0] sw_sync;
  always_ff @(posedge Clock) begin
    if (Reset) sw_sync <= '0;
    else       sw_sync <= {sw_sync[0], sw_en};
  end
  assign sw = sw_sync[1];
`else
  assign sw = sw_en;
`endif

  assign op        = op_t'(ir[FUNC_LSB +: FUNC_W]);
  assign rf_addr_d = ir[RD_LSB +: RD_W];
  assign rf_addr_s = ir[RS_LSB +: RS_W];
  assign imm       = ir[IMM_LSB +: IMM_W];
  assign unused_ir = ir[15];

  pico_mul_seq #(.DATA_W(DATA_W)) u_mul (
    .clk     (Clock),
    .rst     (Reset),
    .start   (mul_start),
    .a       (rd_data),
    .b       (rs_data),
    .done    (mul_done),
    .product (product)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= FETCH;
      pc    <= '0;
      ir    <= '0;
    end else begin
      state <= state_nx;
      if (state == FETCH) ir <= instr;
      if (pc_jump)     pc <= imm[PC_W-1:0];
      else if (pc_inc) pc <= pc + 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      FETCH: state_nx = EXEC;
      EXEC: begin
        case (op)
          OP_MUL:  state_nx = MUL;
          OP_HEN:  state_nx = WAIT_HI;
          OP_HEQ:  state_nx = WAIT_LO;
          default: state_nx = FETCH;
        endcase
      end
      MUL:     if (mul_done) state_nx = WB;
      WB:      state_nx = FETCH;
      WAIT_HI: if (sw)  state_nx = FETCH;
      WAIT_LO: if (!sw) state_nx = FETCH;
      default: state_nx = FETCH;
    endcase
  end

  always_comb begin
    we_raw      = 1'b0;
    rf_wdata    = '0;
    mul_start   = 1'b0;
    pc_inc      = 1'b0;
    pc_jump     = 1'b0;
    illegal_raw = 1'b0;
    busy        = 1'b0;
    case (state)
      EXEC: begin
        case (op)
          OP_ADD: begin
            we_raw   = 1'b1;
            rf_wdata = rd_data + rs_data;
            pc_inc   = 1'b1;
          end
          OP_SUB: begin
            we_raw   = 1'b1;
            rf_wdata = rd_data - rs_data;
            pc_inc   = 1'b1;
          end
          OP_LI: begin
            we_raw   = 1'b1;
            rf_wdata = DATA_W'(imm);
            pc_inc   = 1'b1;
          end
          OP_MUL: mul_start = 1'b1;
          OP_J:   pc_jump   = 1'b1;
          OP_ILL: begin
            illegal_raw = 1'b1;
            pc_inc      = 1'b1;
          end
          default: ;
        endcase
      end
      MUL: busy = 1'b1;
      WB: begin
        we_raw   = 1'b1;
        rf_wdata = (MUL_HI != 0) ? product[2*DATA_W-1 -: DATA_W] : product[DATA_W-1:0];
        pc_inc   = 1'b1;
      end
      WAIT_HI: begin
        busy   = 1'b1;
        pc_inc = sw;
      end
      WAIT_LO: begin
        busy   = 1'b1;
        pc_inc = !sw;
      end
      default: ;
    endcase
  end

  // Reset gates the strobes so an aborted instruction never writes or flags
  assign rf_we   = we_raw && (rf_addr_d != 4'd0) && !Reset;
  assign illegal = illegal_raw && !Reset;

endmodule

// File: tb/tb_pico_seq_ctrl.sv
// Scoreboard bench for pico_seq_ctrl: expected writes queued at stimulus time, popped on rf_we.
module tb_pico_seq_ctrl;

  localparam int unsigned PC_W   = 3;
  localparam int unsigned DATA_W = 8;

  localparam logic [2:0] T_ADD = 3'b000, T_SUB = 3'b001, T_MUL = 3'b010, T_LI = 3'b011,
                         T_HEN = 3'b100, T_HEQ = 3'b101, T_J = 3'b110, T_ILL = 3'b111;

`ifdef PICO_SW_SYNC_EN
  localparam int SW_LAT = 2;
`else
  localparam int SW_LAT = 0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [15:0]       instr;
  logic              sw_en = 1'b0;
  logic [DATA_W-1:0] rd_data, rs_data;
  logic [PC_W-1:0]   pc;
  logic [3:0]        rf_addr_d, rf_addr_s;
  logic              rf_we;
  logic [DATA_W-1:0] rf_wdata;
  logic              busy, illegal;

  logic [15:0] prog [8];
  logic [7:0]  rf   [16];

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
    int         cyc;
  } wr_t;
  wr_t exp_q[$];

  int tests = 0;
  int fails = 0;
  int cyc = 1;
  int busy_cnt = 0;
  int ill_cnt = 0;
  int ill_cyc = 0;

  always #5 clk = ~clk;

  assign instr   = prog[pc];
  assign rd_data = rf[rf_addr_d];
  assign rs_data = rf[rf_addr_s];

  pico_seq_ctrl #(.PC_W(PC_W), .DATA_W(DATA_W), .MUL_HI(1)) dut (
    .Clock     (clk),
    .Reset     (rst),
    .instr     (instr),
    .sw_en     (sw_en),
    .rd_data   (rd_data),
    .rs_data   (rs_data),
    .pc        (pc),
    .rf_addr_d (rf_addr_d),
    .rf_addr_s (rf_addr_s),
    .rf_we     (rf_we),
    .rf_wdata  (rf_wdata),
    .busy      (busy),
    .illegal   (illegal)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] enc_r(input logic [2:0] op, input int rd, input int rs);
    return {5'b0, 4'(rs), 4'(rd), op};
  endfunction

  function automatic logic [15:0] enc_i(input logic [2:0] op, input int rd, input int imm);
    return {1'b0, 8'(imm), 4'(rd), op};
  endfunction

  // cycle 1 is the FETCH cycle right after reset release
  always @(posedge clk) begin
    if (rst) cyc <= 1;
    else     cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (rst) begin
      busy_cnt = 0;
      ill_cnt  = 0;
    end
    if (busy) busy_cnt++;
    if (illegal) begin
      ill_cnt++;
      ill_cyc = cyc;
    end
    if (rf_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_we", 32'd1, 32'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("we_addr", rf_addr_d, e.addr);
        check("we_data", rf_wdata, e.data);
        check("we_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic wait_cyc(input int n);
    int guard = 0;
    while (cyc != n && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != n) check("wait_timeout", cyc, n);
    #1;
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++)  prog[i] = enc_i(T_J, 0, 0);
    for (int i = 0; i < 16; i++) rf[i] = 8'd0;

    // Phase A: LI / ADD / SUB / illegal / Rd==0 / jump / pc wrap
    rst = 1'b1;
    rf[1] = 8'd200; rf[2] = 8'd100; rf[3] = 8'd3; rf[4] = 8'd5;
    prog[0] = enc_i(T_LI, 1, 5);
    prog[1] = enc_r(T_ADD, 1, 2);
    prog[2] = enc_r(T_SUB, 3, 4);
    prog[3] = enc_r(T_ILL, 5, 0);
    prog[4] = enc_r(T_ADD, 0, 1);
    prog[5] = enc_i(T_J, 0, 7);
    prog[6] = enc_i(T_LI, 6, 8'h11);
    prog[7] = enc_i(T_LI, 7, 8'hAB);
    exp_q.push_back('{4'd1, 8'd5,   2});
    exp_q.push_back('{4'd1, 8'd44,  4});
    exp_q.push_back('{4'd3, 8'd254, 6});
    exp_q.push_back('{4'd7, 8'hAB,  14});
    @(negedge clk); #1;
    check("rst_pc", pc, 0);
    check("rst_busy", busy, 0);
    check("rst_we", rf_we, 0);
    check("rst_illegal", illegal, 0);
    release_reset();
    wait_cyc(1);
    check("c1_pc", pc, 0);
    check("c1_addr_d", rf_addr_d, 0);
    check("c1_busy", busy, 0);
    wait_cyc(3);
    check("li_pc", pc, 1);
    wait_cyc(13);
    check("jump_pc", pc, 7);
    wait_cyc(15);
    check("wrap_pc", pc, 0);
    check("ill_count", ill_cnt, 1);
    check("ill_cycle", ill_cyc, 8);
    check("a_busy", busy_cnt, 0);
    check("a_queue", exp_q.size(), 0);

    // Phase B: two MULs (high half), then self-jump halt
    rst = 1'b1;
    rf[1] = 8'h80; rf[2] = 8'h40; rf[3] = 8'hFF; rf[4] = 8'hFF;
    for (int i = 0; i < 8; i++) prog[i] = enc_i(T_J, 0, 2);
    prog[0] = enc_r(T_MUL, 1, 2);
    prog[1] = enc_r(T_MUL, 3, 4);
    exp_q.push_back('{4'd1, 8'h20, 11});
    exp_q.push_back('{4'd3, 8'hFE, 22});
    release_reset();
    wait_cyc(10);
    check("mul_busy", busy, 1);
    check("mul_pc", pc, 0);
    wait_cyc(11);
    check("wb_busy", busy, 0);
    check("mul_busy_cnt", busy_cnt, 8);
    wait_cyc(12);
    check("mul_pc_next", pc, 1);
    wait_cyc(30);
    check("halt_pc", pc, 2);
    check("b_busy_cnt", busy_cnt, 16);
    check("b_queue", exp_q.size(), 0);

    // Phase C: HEN then HEQ handshakes
    rst = 1'b1;
    for (int i = 0; i < 8; i++) prog[i] = enc_i(T_J, 0, 2);
    prog[0] = enc_r(T_HEN, 0, 0);
    prog[1] = enc_r(T_HEQ, 0, 0);
    sw_en = 1'b0;
    release_reset();
    wait_cyc(12);
    check("hen_pc_frozen", pc, 0);
    check("hen_busy", busy, 1);
    sw_en = 1'b1;
    wait_cyc(12 + SW_LAT);
    check("hen_pc_hold", pc, 0);
    wait_cyc(13 + SW_LAT);
    check("hen_pc_adv", pc, 1);
    wait_cyc(20);
    check("heq_pc_frozen", pc, 1);
    check("heq_busy", busy, 1);
    sw_en = 1'b0;
    wait_cyc(20 + SW_LAT);
    check("heq_pc_hold", pc, 1);
    wait_cyc(21 + SW_LAT);
    check("heq_pc_adv", pc, 2);
    check("c_ill", ill_cnt, 0);
    check("c_queue", exp_q.size(), 0);

    // Phase D: reset mid-MUL aborts it; a following MUL starts clean
    rst = 1'b1;
    rf[1] = 8'h80; rf[2] = 8'h40; rf[3] = 8'hC8; rf[4] = 8'h0A;
    for (int i = 0; i < 8; i++) prog[i] = enc_i(T_J, 0, 3);
    prog[0] = enc_i(T_J, 0, 3);
    prog[3] = enc_r(T_MUL, 1, 2);
    release_reset();
    wait_cyc(8);
    check("abort_busy", busy, 1);
    check("abort_pc", pc, 3);
    rst = 1'b1;
    @(negedge clk); #1;
    check("abort_pc_rst", pc, 0);
    check("abort_busy_rst", busy, 0);
    check("abort_we", rf_we, 0);
    for (int i = 0; i < 8; i++) prog[i] = enc_i(T_J, 0, 1);
    prog[0] = enc_r(T_MUL, 3, 4);
    exp_q.push_back('{4'd3, 8'h07, 11});
    release_reset();
    wait_cyc(25);
    check("d_pc", pc, 1);
    check("d_queue", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
